// File: rtl/uart_tx_frame.sv
// UART transmitter: start / LSB-first data / optional parity / stop, each bit i_Prescale clocks (0 means 2^PRESCALE_W).
// Define UART_TX_STOP2_EN to add i_STOP2, which selects a second stop bit per frame.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_PAR_EN,
  input  logic                  i_PAR_TYP,
  input  logic [PRESCALE_W-1:0] i_Prescale,
`ifdef UART_TX_STOP2_EN
  input  logic                  i_STOP2,
`endif
  output logic                  o_tx_out,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]      ONE_B    = BIT_W'(1);
  localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    stop2_q, stop2_d;
  logic                    stop_hi_q, stop_hi_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  // Wraps for a latched prescale of 0, giving a full 2^PRESCALE_W count.
  assign bit_end = (cnt_q == (presc_q - ONE_P));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_hi_d = stop_hi_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : (cnt_q + ONE_P);
    end

    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          state_d   = START;
          presc_d   = i_Prescale;
          shift_d   = i_p_data;
          par_en_d  = i_PAR_EN;
          par_bit_d = (^i_p_data) ^ i_PAR_TYP;
`ifdef UART_TX_STOP2_EN
          stop2_d   = i_STOP2;
`else
          stop2_d   = 1'b0;
`endif
          stop_hi_d = 1'b0;
          bit_d     = '0;
          cnt_d     = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + ONE_B;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // stop_hi_q marks that the first of two stop bits has elapsed.
          if (stop2_q && !stop_hi_q) begin
            stop_hi_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_tx_out  = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: expected {tx,busy,done} per cycle queued at send time, compared against captured samples.
module tb_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld;
  logic [7:0] pdata;
  logic       par_en;
  logic       par_typ;
  logic [5:0] presc;
`ifdef UART_TX_STOP2_EN
  logic       stop2;
`endif
  logic       tx, busy, done;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_data_valid(vld),
    .i_p_data(pdata),
    .i_PAR_EN(par_en),
    .i_PAR_TYP(par_typ),
    .i_Prescale(presc),
`ifdef UART_TX_STOP2_EN
    .i_STOP2(stop2),
`endif
    .o_tx_out(tx),
    .o_busy(busy),
    .o_tx_done(done)
  );

  task automatic push_bit(input logic b, input int pc);
    repeat (pc) exp_q.push_back({b, 1'b1, 1'b0});
  endtask

  // Expected frame: every cycle of every bit, then the idle cycle carrying the done pulse.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] p, input logic s2);
    int pc;
    pc = (p == 6'd0) ? 64 : int'(p);
    push_bit(1'b0, pc);
    for (int i = 0; i < 8; i++) push_bit(d[i], pc);
    if (pe) push_bit((^d) ^ pt, pc);
    push_bit(1'b1, pc);
    if (s2) push_bit(1'b1, pc);
    exp_q.push_back(3'b101);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] p, input logic s2);
    pdata = d; par_en = pe; par_typ = pt; presc = p;
`ifdef UART_TX_STOP2_EN
    stop2 = s2;
`endif
    vld = 1'b1;
    push_frame(d, pe, pt, p, s2);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      obs_q.push_back({tx, busy, done});
      @(negedge clk);
    end
  endtask

  task automatic drain(output int nbad, output int first, output logic [2:0] act, output logic [2:0] expv);
    logic [2:0] o, e;
    int idx;
    nbad = 0; first = -1; act = '0; expv = '0; idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        if (nbad == 0) begin first = idx; act = o; expv = e; end
        nbad++;
      end
      idx++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [9:0] pat, got;
    int nb, nd, nbad, first;
    logic [2:0] a, e;
    pat = 10'b1101001010;
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    capture(81);
    got = '0; nb = 0; nd = 0;
    for (int k = 0; k < 10; k++) got[k] = obs_q[k*8 + 4][2];
    for (int i = 0; i < obs_q.size(); i++) begin nb += int'(obs_q[i][1]); nd += int'(obs_q[i][0]); end
    checks++; if (got !== pat) begin errors++; $display("FAIL basic_bits: got %b expected %b", got, pat); end
    checks++; if (nb !== 80) begin errors++; $display("FAIL basic_busy_len: got %0d expected 80", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", nd); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL basic_stream: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
  endtask

  task automatic test_parity;
    int nb, nbad, first;
    logic [2:0] a, e;
    logic pexp;
    for (int t = 0; t < 2; t++) begin
      pexp = (t == 0) ? 1'b1 : 1'b0;
      send(8'h07, 1'b1, t[0], 6'd16, 1'b0);
      capture(177);
      nb = 0;
      for (int i = 0; i < obs_q.size(); i++) nb += int'(obs_q[i][1]);
      checks++; if (obs_q[9*16 + 8][2] !== pexp) begin errors++; $display("FAIL parity_bit typ=%0d: got %b expected %b", t, obs_q[9*16 + 8][2], pexp); end
      checks++; if (nb !== 176) begin errors++; $display("FAIL parity_busy_len typ=%0d: got %0d expected 176", t, nb); end
      drain(nbad, first, a, e);
      checks++; if (nbad !== 0) begin errors++; $display("FAIL parity_stream typ=%0d: %0d bad, first at %0d got %b expected %b", t, nbad, first, a, e); end
    end
  endtask

  task automatic test_back_to_back;
    int nd, gap, nbad, first;
    logic [2:0] a, e;
    pdata = 8'h55; par_en = 1'b0; par_typ = 1'b0; presc = 6'd4;
`ifdef UART_TX_STOP2_EN
    stop2 = 1'b0;
`endif
    vld = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0, 6'd4, 1'b0);
    push_frame(8'hFF, 1'b0, 1'b0, 6'd4, 1'b0);
    @(negedge clk);
    pdata = 8'hFF;
    fork
      begin
        repeat (41) @(negedge clk);
        vld = 1'b0;
      end
    join_none
    capture(82);
    nd = 0; gap = -1;
    for (int i = 0; i < obs_q.size(); i++) nd += int'(obs_q[i][0]);
    for (int i = 37; i < obs_q.size(); i++) begin
      if (gap < 0 && obs_q[i][2] === 1'b0) gap = i - 36;
    end
    checks++; if (gap !== 5) begin errors++; $display("FAIL b2b_gap: got %0d expected 5", gap); end
    checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 2", nd); end
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL b2b_stream: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got busy %b expected 0", busy); end
  endtask

  task automatic test_latch;
    int nb, nbad, first;
    logic [2:0] a, e;
    send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
    capture(20);
    pdata = 8'hC3; presc = 6'd32; par_en = 1'b1; par_typ = 1'b1;
    capture(61);
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL latch_inflight: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
    send(8'hC3, 1'b1, 1'b1, 6'd32, 1'b0);
    capture(353);
    nb = 0;
    for (int i = 0; i < obs_q.size(); i++) nb += int'(obs_q[i][1]);
    checks++; if (nb !== 352) begin errors++; $display("FAIL latch_next_len: got %0d expected 352", nb); end
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL latch_next_stream: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
  endtask

  task automatic test_reset_mid;
    int nbad, first;
    logic [2:0] a, e;
    send(8'h96, 1'b0, 1'b0, 6'd8, 1'b0);
    capture(35);
    while (exp_q.size() > 35) void'(exp_q.pop_back());
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_partial: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({tx, busy, done} !== 3'b100) begin errors++; $display("FAIL midrst_after: got %b expected 100", {tx, busy, done}); end
    send(8'h5A, 1'b1, 1'b0, 6'd8, 1'b0);
    capture(89);
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_clean: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
  endtask

  task automatic test_prescale_zero;
    int nbad, first;
    logic [2:0] a, e;
    send(8'h81, 1'b1, 1'b1, 6'd0, 1'b0);
    capture(705);
    checks++; if (obs_q[63][2] !== 1'b0) begin errors++; $display("FAIL p0_start_end: got %b expected 0", obs_q[63][2]); end
    checks++; if (obs_q[64][2] !== 1'b1) begin errors++; $display("FAIL p0_bit0_begin: got %b expected 1", obs_q[64][2]); end
    checks++; if (obs_q[9*64 + 10][2] !== 1'b1) begin errors++; $display("FAIL p0_parity: got %b expected 1", obs_q[9*64 + 10][2]); end
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL p0_stream: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
  endtask

`ifdef UART_TX_STOP2_EN
  task automatic test_stop2;
    int nb, nbad, first;
    logic [2:0] a, e;
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);
    capture(89);
    nb = 0;
    for (int i = 0; i < obs_q.size(); i++) nb += int'(obs_q[i][1]);
    checks++; if (nb !== 88) begin errors++; $display("FAIL stop2_busy_len: got %0d expected 88", nb); end
    drain(nbad, first, a, e);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL stop2_stream: %0d bad, first at %0d got %b expected %b", nbad, first, a, e); end
    stop2 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; vld = 1'b0; pdata = '0; par_en = 1'b0; par_typ = 1'b0; presc = 6'd8;
`ifdef UART_TX_STOP2_EN
    stop2 = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_latch;
    test_reset_mid;
    test_prescale_zero;
`ifdef UART_TX_STOP2_EN
    test_stop2;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
